// File: rtl/mips_exec_control.sv
// mips_exec_control: MIPS-I decoder, ALU, branch compare and HI/LO
// registers for the single-cycle Harvard core.
module mips_exec_control (
    input  logic        clk,
    input  logic        reset,
    input  logic        clk_enable,
    input  logic        active,
    input  logic [31:0] instr_readdata,
    input  logic [31:0] reg_data_a,
    input  logic [31:0] reg_data_b,
    output logic [31:0] alu_result,
    output logic        branch_is_true,
    output logic [1:0]  pc_sel,
    output logic [1:0]  reg_addr_sel,
    output logic [1:0]  reg_data_sel,
    output logic        alu_sel,
    output logic        signextend_sel,
    output logic        reg_write_enable,
    output logic        data_write,
    output logic        data_read,
    output logic [3:0]  byte_enable
);
    localparam logic [5:0] OP_SPECIAL = 6'd0,  OP_REGIMM = 6'd1;
    localparam logic [5:0] OP_J       = 6'd2,  OP_JAL    = 6'd3;
    localparam logic [5:0] OP_BEQ     = 6'd4,  OP_BNE    = 6'd5;
    localparam logic [5:0] OP_BLEZ    = 6'd6,  OP_BGTZ   = 6'd7;
    localparam logic [5:0] OP_ADDIU   = 6'd9,  OP_SLTI   = 6'd10;
    localparam logic [5:0] OP_SLTIU   = 6'd11, OP_ANDI   = 6'd12;
    localparam logic [5:0] OP_ORI     = 6'd13, OP_XORI   = 6'd14;
    localparam logic [5:0] OP_LUI     = 6'd15, OP_LB     = 6'd32;
    localparam logic [5:0] OP_LH      = 6'd33, OP_LW     = 6'd35;
    localparam logic [5:0] OP_LBU     = 6'd36, OP_LHU    = 6'd37;
    localparam logic [5:0] OP_SB      = 6'd40, OP_SH     = 6'd41;
    localparam logic [5:0] OP_SW      = 6'd43;

    localparam logic [5:0] FN_SLL  = 6'd0,  FN_SRL   = 6'd2;
    localparam logic [5:0] FN_SRA  = 6'd3,  FN_SLLV  = 6'd4;
    localparam logic [5:0] FN_SRLV = 6'd6,  FN_SRAV  = 6'd7;
    localparam logic [5:0] FN_JR   = 6'd8,  FN_JALR  = 6'd9;
    localparam logic [5:0] FN_MFHI = 6'd16, FN_MTHI  = 6'd17;
    localparam logic [5:0] FN_MFLO = 6'd18, FN_MTLO  = 6'd19;
    localparam logic [5:0] FN_MULT = 6'd24, FN_MULTU = 6'd25;
    localparam logic [5:0] FN_DIV  = 6'd26, FN_DIVU  = 6'd27;
    localparam logic [5:0] FN_ADDU = 6'd33, FN_SUBU  = 6'd35;
    localparam logic [5:0] FN_AND  = 6'd36, FN_OR    = 6'd37;
    localparam logic [5:0] FN_XOR  = 6'd38, FN_SLT   = 6'd42;
    localparam logic [5:0] FN_SLTU = 6'd43;

    localparam logic [4:0] RI_BLTZ   = 5'd0,  RI_BGEZ   = 5'd1;
    localparam logic [4:0] RI_BLTZAL = 5'd16, RI_BGEZAL = 5'd17;

    logic [5:0]  opcode, funct;
    logic [4:0]  rt, shamt, shv;
    logic [31:0] a, b, imm_s, imm_z, addr;
    logic [31:0] hi, lo, hi_next, lo_next;
    logic [63:0] prod_s, prod_u;
    logic [31:0] mag_a, mag_b, uquot, urem, squot, srem;
    logic        a_neg, a_zero, run, we, dw, dr;
    logic        unused_rs;

    assign opcode    = instr_readdata[31:26];
    assign rt        = instr_readdata[20:16];
    assign shamt     = instr_readdata[10:6];
    assign funct     = instr_readdata[5:0];
    assign unused_rs = ^instr_readdata[25:21];
    assign a         = reg_data_a;
    assign b         = reg_data_b;
    assign shv       = a[4:0];
    assign imm_s     = {{16{instr_readdata[15]}}, instr_readdata[15:0]};
    assign imm_z     = {16'h0, instr_readdata[15:0]};
    assign addr      = a + imm_s;
    assign a_neg     = a[31];
    assign a_zero    = (a == 32'd0);

    assign prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    assign prod_u = {32'd0, a} * {32'd0, b};

    // Signed divide on magnitudes keeps INT_MIN / -1 well defined
    assign mag_a = a[31] ? -a : a;
    assign mag_b = b[31] ? -b : b;
    assign uquot = mag_a / mag_b;
    assign urem  = mag_a % mag_b;
    assign squot = (a[31] ^ b[31]) ? -uquot : uquot;
    assign srem  = a[31] ? -urem : urem;

    always_comb begin
        alu_result     = 32'd0;
        branch_is_true = 1'b0;
        pc_sel         = 2'd0;
        reg_addr_sel   = 2'd0;
        reg_data_sel   = 2'd0;
        alu_sel        = 1'b0;
        signextend_sel = 1'b0;
        byte_enable    = 4'b0000;
        we             = 1'b0;
        dw             = 1'b0;
        dr             = 1'b0;
        hi_next        = hi;
        lo_next        = lo;
        case (opcode)
            OP_SPECIAL: begin
                reg_addr_sel = 2'd1;
                we           = 1'b1;
                case (funct)
                    FN_SLL:  alu_result = b << shamt;
                    FN_SRL:  alu_result = b >> shamt;
                    FN_SRA:  alu_result = $signed(b) >>> shamt;
                    FN_SLLV: alu_result = b << shv;
                    FN_SRLV: alu_result = b >> shv;
                    FN_SRAV: alu_result = $signed(b) >>> shv;
                    FN_ADDU: alu_result = a + b;
                    FN_SUBU: alu_result = a - b;
                    FN_AND:  alu_result = a & b;
                    FN_OR:   alu_result = a | b;
                    FN_XOR:  alu_result = a ^ b;
                    FN_SLT:  alu_result = {31'd0, $signed(a) < $signed(b)};
                    FN_SLTU: alu_result = {31'd0, a < b};
                    FN_MFHI: alu_result = hi;
                    FN_MFLO: alu_result = lo;
                    FN_JALR: begin
                        pc_sel         = 2'd3;
                        branch_is_true = 1'b1;
                        reg_data_sel   = 2'd3;
                    end
                    default: begin
                        reg_addr_sel = 2'd0;
                        we           = 1'b0;
                        case (funct)
                            FN_JR: begin
                                pc_sel         = 2'd3;
                                branch_is_true = 1'b1;
                            end
                            FN_MTHI:  hi_next = a;
                            FN_MTLO:  lo_next = a;
                            FN_MULT:  {hi_next, lo_next} = prod_s;
                            FN_MULTU: {hi_next, lo_next} = prod_u;
                            FN_DIV: if (b != 32'd0) begin
                                hi_next = srem;
                                lo_next = squot;
                            end
                            FN_DIVU: if (b != 32'd0) begin
                                hi_next = a % b;
                                lo_next = a / b;
                            end
                            default: ;
                        endcase
                    end
                endcase
            end
            OP_REGIMM: begin
                case (rt)
                    RI_BLTZ, RI_BLTZAL: begin
                        pc_sel         = 2'd1;
                        signextend_sel = 1'b1;
                        branch_is_true = a_neg;
                    end
                    RI_BGEZ, RI_BGEZAL: begin
                        pc_sel         = 2'd1;
                        signextend_sel = 1'b1;
                        branch_is_true = !a_neg;
                    end
                    default: ;
                endcase
                // Linking branches write r31 whether or not taken
                if (rt == RI_BLTZAL || rt == RI_BGEZAL) begin
                    reg_addr_sel = 2'd2;
                    reg_data_sel = 2'd3;
                    we           = 1'b1;
                end
            end
            OP_J, OP_JAL: begin
                pc_sel         = 2'd2;
                branch_is_true = 1'b1;
                if (opcode == OP_JAL) begin
                    reg_addr_sel = 2'd2;
                    reg_data_sel = 2'd3;
                    we           = 1'b1;
                end
            end
            OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: begin
                pc_sel         = 2'd1;
                signextend_sel = 1'b1;
                case (opcode)
                    OP_BEQ:  branch_is_true = (a == b);
                    OP_BNE:  branch_is_true = (a != b);
                    OP_BLEZ: branch_is_true = a_neg | a_zero;
                    default: branch_is_true = !a_neg & !a_zero;
                endcase
            end
            OP_ADDIU, OP_SLTI, OP_SLTIU,
            OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
                alu_sel = 1'b1;
                we      = 1'b1;
                case (opcode)
                    OP_ADDIU: alu_result = a + imm_s;
                    OP_SLTI:  alu_result = {31'd0, $signed(a) < $signed(imm_s)};
                    OP_SLTIU: alu_result = {31'd0, a < imm_s};
                    OP_ANDI:  alu_result = a & imm_z;
                    OP_ORI:   alu_result = a | imm_z;
                    OP_XORI:  alu_result = a ^ imm_z;
                    default:  alu_result = {instr_readdata[15:0], 16'h0};
                endcase
                signextend_sel = (opcode == OP_ADDIU) || (opcode == OP_SLTI) ||
                                 (opcode == OP_SLTIU);
            end
            OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU,
            OP_SB, OP_SH, OP_SW: begin
                alu_sel        = 1'b1;
                alu_result     = addr;
                signextend_sel = (opcode != OP_LBU) && (opcode != OP_LHU);
                dr             = !opcode[3];
                dw             = opcode[3];
                we             = !opcode[3];
                if (!opcode[3])
                    reg_data_sel = (opcode == OP_LW) ? 2'd1 : 2'd2;
                case (opcode)
                    OP_LW, OP_SW:         byte_enable = 4'b1111;
                    OP_LB, OP_LBU, OP_SB: byte_enable = 4'b0001 << addr[1:0];
                    default:              byte_enable = addr[1] ? 4'b1100 : 4'b0011;
                endcase
            end
            default: ;
        endcase
    end

    assign run              = active & clk_enable;
    assign reg_write_enable = we & run & reset;
    assign data_write       = dw & run & reset;
    assign data_read        = dr & run & reset;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hi <= 32'd0;
            lo <= 32'd0;
        end else if (run) begin
            hi <= hi_next;
            lo <= lo_next;
        end
    end
endmodule

// File: tb/tb_mips_exec_control.sv
// tb_mips_exec_control: directed scenarios plus randomized instructions
// checked against an instruction-level reference model.
module tb_mips_exec_control;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        clk_enable = 1'b1;
    logic        active = 1'b1;
    logic [31:0] instr_readdata = 32'd0;
    logic [31:0] reg_data_a = 32'd0;
    logic [31:0] reg_data_b = 32'd0;
    logic [31:0] alu_result;
    logic        branch_is_true;
    logic [1:0]  pc_sel, reg_addr_sel, reg_data_sel;
    logic        alu_sel, signextend_sel;
    logic        reg_write_enable, data_write, data_read;
    logic [3:0]  byte_enable;

    int vectors = 0;
    int miscompares = 0;

    mips_exec_control dut (
        .clk(clk), .reset(reset), .clk_enable(clk_enable), .active(active),
        .instr_readdata(instr_readdata), .reg_data_a(reg_data_a),
        .reg_data_b(reg_data_b), .alu_result(alu_result),
        .branch_is_true(branch_is_true), .pc_sel(pc_sel),
        .reg_addr_sel(reg_addr_sel), .reg_data_sel(reg_data_sel),
        .alu_sel(alu_sel), .signextend_sel(signextend_sel),
        .reg_write_enable(reg_write_enable), .data_write(data_write),
        .data_read(data_read), .byte_enable(byte_enable)
    );

    always #5 clk = ~clk;

    typedef enum {
        I_NOP, I_SLL, I_SRL, I_SRA, I_SLLV, I_SRLV, I_SRAV, I_JR, I_JALR,
        I_MFHI, I_MTHI, I_MFLO, I_MTLO, I_MULT, I_MULTU, I_DIV, I_DIVU,
        I_ADDU, I_SUBU, I_AND, I_OR, I_XOR, I_SLT, I_SLTU,
        I_BLTZ, I_BGEZ, I_BLTZAL, I_BGEZAL, I_J, I_JAL, I_BEQ, I_BNE,
        I_BLEZ, I_BGTZ, I_ADDIU, I_SLTI, I_SLTIU, I_ANDI, I_ORI, I_XORI,
        I_LUI, I_LB, I_LH, I_LW, I_LBU, I_LHU, I_SB, I_SH, I_SW
    } op_e;

    typedef struct packed {
        logic [31:0] res;
        logic        br;
        logic [1:0]  pcs, ras, rds;
        logic        als, sxs, we, dw, dr;
        logic [3:0]  be;
    } exp_t;

    logic [5:0] spec_f [0:22] = '{0, 2, 3, 4, 6, 7, 8, 9, 16, 17, 18, 19,
                                  24, 25, 26, 27, 33, 35, 36, 37, 38, 42, 43};
    logic [5:0] main_op [0:21] = '{2, 3, 4, 5, 6, 7, 9, 10, 11, 12, 13, 14,
                                   15, 32, 33, 35, 36, 37, 40, 41, 43, 4};
    logic [4:0] ri_rt [0:3] = '{0, 1, 16, 17};

    function automatic op_e decode(input logic [31:0] w);
        op_e op;
        op = I_NOP;
        case (w[31:26])
            6'd0: case (w[5:0])
                6'd0: op = I_SLL;    6'd2: op = I_SRL;   6'd3: op = I_SRA;
                6'd4: op = I_SLLV;   6'd6: op = I_SRLV;  6'd7: op = I_SRAV;
                6'd8: op = I_JR;     6'd9: op = I_JALR;  6'd16: op = I_MFHI;
                6'd17: op = I_MTHI;  6'd18: op = I_MFLO; 6'd19: op = I_MTLO;
                6'd24: op = I_MULT;  6'd25: op = I_MULTU;
                6'd26: op = I_DIV;   6'd27: op = I_DIVU;
                6'd33: op = I_ADDU;  6'd35: op = I_SUBU; 6'd36: op = I_AND;
                6'd37: op = I_OR;    6'd38: op = I_XOR;  6'd42: op = I_SLT;
                6'd43: op = I_SLTU;
                default: op = I_NOP;
            endcase
            6'd1: case (w[20:16])
                5'd0: op = I_BLTZ;    5'd1: op = I_BGEZ;
                5'd16: op = I_BLTZAL; 5'd17: op = I_BGEZAL;
                default: op = I_NOP;
            endcase
            6'd2: op = I_J;      6'd3: op = I_JAL;    6'd4: op = I_BEQ;
            6'd5: op = I_BNE;    6'd6: op = I_BLEZ;   6'd7: op = I_BGTZ;
            6'd9: op = I_ADDIU;  6'd10: op = I_SLTI;  6'd11: op = I_SLTIU;
            6'd12: op = I_ANDI;  6'd13: op = I_ORI;   6'd14: op = I_XORI;
            6'd15: op = I_LUI;   6'd32: op = I_LB;    6'd33: op = I_LH;
            6'd35: op = I_LW;    6'd36: op = I_LBU;   6'd37: op = I_LHU;
            6'd40: op = I_SB;    6'd41: op = I_SH;    6'd43: op = I_SW;
            default: op = I_NOP;
        endcase
        return op;
    endfunction

    function automatic exp_t model(input logic [31:0] w, input logic [31:0] a,
                                   input logic [31:0] b, input logic [31:0] hi,
                                   input logic [31:0] lo, input logic on);
        exp_t e;
        op_e op;
        int sa, sb;
        int unsigned sh, shv;
        logic [31:0] si, zi, addr;
        bit rd_w, rt_w, ld, st, br, lk;
        e = '0;
        op = decode(w);
        sa = $signed(a);
        sb = $signed(b);
        sh = {27'd0, w[10:6]};
        shv = {27'd0, a[4:0]};
        si = {{16{w[15]}}, w[15:0]};
        zi = {16'h0, w[15:0]};
        addr = a + si;
        rd_w = op inside {I_SLL, I_SRL, I_SRA, I_SLLV, I_SRLV, I_SRAV, I_ADDU,
                          I_SUBU, I_AND, I_OR, I_XOR, I_SLT, I_SLTU, I_MFHI, I_MFLO};
        rt_w = op inside {I_ADDIU, I_SLTI, I_SLTIU, I_ANDI, I_ORI, I_XORI, I_LUI};
        ld = op inside {I_LB, I_LH, I_LW, I_LBU, I_LHU};
        st = op inside {I_SB, I_SH, I_SW};
        br = op inside {I_BEQ, I_BNE, I_BLEZ, I_BGTZ, I_BLTZ, I_BGEZ, I_BLTZAL, I_BGEZAL};
        lk = op inside {I_JAL, I_BLTZAL, I_BGEZAL};
        case (op)
            I_SLL: e.res = b << sh;
            I_SRL: e.res = b >> sh;
            I_SRA: e.res = sb >>> sh;
            I_SLLV: e.res = b << shv;
            I_SRLV: e.res = b >> shv;
            I_SRAV: e.res = sb >>> shv;
            I_ADDU: e.res = a + b;
            I_SUBU: e.res = a - b;
            I_AND: e.res = a & b;
            I_OR: e.res = a | b;
            I_XOR: e.res = a ^ b;
            I_SLT: e.res = {31'd0, sa < sb};
            I_SLTU: e.res = {31'd0, a < b};
            I_MFHI: e.res = hi;
            I_MFLO: e.res = lo;
            I_ADDIU: e.res = a + si;
            I_SLTI: e.res = {31'd0, sa < $signed(si)};
            I_SLTIU: e.res = {31'd0, a < si};
            I_ANDI: e.res = a & zi;
            I_ORI: e.res = a | zi;
            I_XORI: e.res = a ^ zi;
            I_LUI: e.res = {w[15:0], 16'h0};
            default: e.res = (ld || st) ? addr : 32'd0;
        endcase
        if (rd_w) begin e.ras = 2'd1; e.we = on; end
        if (rt_w) begin
            e.als = 1'b1;
            e.we = on;
            e.sxs = op inside {I_ADDIU, I_SLTI, I_SLTIU};
        end
        if (ld || st) begin
            e.als = 1'b1;
            e.sxs = !(op inside {I_LBU, I_LHU});
            e.dr = ld & on;
            e.dw = st & on;
            e.we = ld & on;
            e.rds = (op == I_LW) ? 2'd1 : (ld ? 2'd2 : 2'd0);
            if (op inside {I_LW, I_SW}) e.be = 4'b1111;
            else if (op inside {I_LB, I_LBU, I_SB}) e.be[addr[1:0]] = 1'b1;
            else e.be = addr[1] ? 4'b1100 : 4'b0011;
        end
        if (br) begin
            e.pcs = 2'd1;
            e.sxs = 1'b1;
            case (op)
                I_BEQ: e.br = (a == b);
                I_BNE: e.br = (a != b);
                I_BLEZ: e.br = (sa <= 0);
                I_BGTZ: e.br = (sa > 0);
                I_BLTZ, I_BLTZAL: e.br = (sa < 0);
                default: e.br = (sa >= 0);
            endcase
        end
        if (op inside {I_J, I_JAL}) begin e.pcs = 2'd2; e.br = 1'b1; end
        if (op inside {I_JR, I_JALR}) begin e.pcs = 2'd3; e.br = 1'b1; end
        if (op == I_JALR) begin e.ras = 2'd1; e.rds = 2'd3; e.we = on; end
        if (lk) begin e.ras = 2'd2; e.rds = 2'd3; e.we = on; end
        return e;
    endfunction

    function automatic logic [63:0] hilo_step(input logic [31:0] w, input logic [31:0] a,
                                              input logic [31:0] b, input logic [63:0] cur,
                                              input logic on);
        logic [63:0] r;
        longint q, rm;
        r = cur;
        if (on) begin
            case (decode(w))
                I_MULT: r = longint'($signed(a)) * longint'($signed(b));
                I_MULTU: r = {32'd0, a} * {32'd0, b};
                I_DIV: if (b != 0) begin
                    q = longint'($signed(a)) / longint'($signed(b));
                    rm = longint'($signed(a)) - q * longint'($signed(b));
                    r = {rm[31:0], q[31:0]};
                end
                I_DIVU: if (b != 0) r = {a % b, a / b};
                I_MTHI: r[63:32] = a;
                I_MTLO: r[31:0] = a;
                default: ;
            endcase
        end
        return r;
    endfunction

    function automatic logic [31:0] enc_r(input logic [5:0] f);
        return {6'd0, 5'd1, 5'd2, 5'd3, 5'd0, f};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [15:0] imm);
        return {op, 5'd1, 5'd2, imm};
    endfunction

    task automatic drive(input logic [31:0] w, input logic [31:0] a, input logic [31:0] b);
        instr_readdata = w;
        reg_data_a = a;
        reg_data_b = b;
        #2;
    endtask

    task automatic test_reset;
        #3 reset = 1'b0;
        drive(enc_r(6'd33), 32'd4, 32'd5);
        vectors++;
        if (reg_write_enable !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_we got=%b exp=0", reg_write_enable);
        end
        drive(enc_i(6'd35, 16'd0), 32'h100, 32'd0);
        vectors++;
        if ({data_read, byte_enable} !== 5'b0_1111) begin
            miscompares++;
            $display("FAIL reset_lw got=%b exp=01111", {data_read, byte_enable});
        end
        drive(enc_r(6'd16), 32'd0, 32'd0);
        vectors++;
        if (alu_result !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_hi got=%h exp=00000000", alu_result);
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_addu;
        @(negedge clk);
        drive(enc_r(6'd33), 32'hFFFF_FFFF, 32'd2);
        vectors++;
        if ({alu_result, reg_addr_sel, reg_write_enable} !== {32'd1, 2'd1, 1'b1}) begin
            miscompares++;
            $display("FAIL addu got=%h/%0d/%b exp=00000001/1/1",
                     alu_result, reg_addr_sel, reg_write_enable);
        end
    endtask

    task automatic test_branch;
        @(negedge clk);
        drive(enc_i(6'd4, 16'd8), 32'd5, 32'd5);
        vectors++;
        if ({branch_is_true, pc_sel} !== 3'b1_01) begin
            miscompares++;
            $display("FAIL beq got=%b/%0d exp=1/1", branch_is_true, pc_sel);
        end
        drive(enc_i(6'd5, 16'd8), 32'd5, 32'd5);
        vectors++;
        if (branch_is_true !== 1'b0) begin
            miscompares++;
            $display("FAIL bne got=%b exp=0", branch_is_true);
        end
    endtask

    task automatic test_store_byte;
        @(negedge clk);
        drive(enc_i(6'd40, 16'd3), 32'h1000, 32'hAB);
        vectors++;
        if ({alu_result, byte_enable, data_write} !== {32'h1003, 4'b1000, 1'b1}) begin
            miscompares++;
            $display("FAIL sb got=%h/%b/%b exp=00001003/1000/1",
                     alu_result, byte_enable, data_write);
        end
        clk_enable = 1'b0;
        #1;
        vectors++;
        if ({data_write, byte_enable} !== 5'b0_1000) begin
            miscompares++;
            $display("FAIL sb_stall got=%b exp=01000", {data_write, byte_enable});
        end
        clk_enable = 1'b1;
        active = 1'b0;
        #1;
        vectors++;
        if (data_write !== 1'b0) begin
            miscompares++;
            $display("FAIL sb_inactive got=%b exp=0", data_write);
        end
        active = 1'b1;
    endtask

    task automatic test_muldiv;
        @(negedge clk);
        drive(enc_r(6'd24), 32'hFFFF_FFFE, 32'd3);
        @(posedge clk);
        @(negedge clk);
        drive(enc_r(6'd16), 32'd0, 32'd0);
        vectors++;
        if (alu_result !== 32'hFFFF_FFFF) begin
            miscompares++;
            $display("FAIL mult_hi got=%h exp=ffffffff", alu_result);
        end
        drive(enc_r(6'd18), 32'd0, 32'd0);
        vectors++;
        if (alu_result !== 32'hFFFF_FFFA) begin
            miscompares++;
            $display("FAIL mult_lo got=%h exp=fffffffa", alu_result);
        end
        drive(enc_r(6'd26), 32'd9, 32'd0);
        @(posedge clk);
        @(negedge clk);
        clk_enable = 1'b0;
        drive(enc_r(6'd17), 32'd55, 32'd0);
        @(posedge clk);
        @(negedge clk);
        clk_enable = 1'b1;
        drive(enc_r(6'd16), 32'd0, 32'd0);
        vectors++;
        if (alu_result !== 32'hFFFF_FFFF) begin
            miscompares++;
            $display("FAIL div0_hi got=%h exp=ffffffff", alu_result);
        end
        drive(enc_r(6'd18), 32'd0, 32'd0);
        vectors++;
        if (alu_result !== 32'hFFFF_FFFA) begin
            miscompares++;
            $display("FAIL div0_lo got=%h exp=fffffffa", alu_result);
        end
    endtask

    task automatic test_jumps;
        @(negedge clk);
        drive({6'd3, 26'h0000100}, 32'd0, 32'd0);
        vectors++;
        if ({pc_sel, reg_addr_sel, reg_data_sel, reg_write_enable} !== 7'b10_10_11_1) begin
            miscompares++;
            $display("FAIL jal got=%0d/%0d/%0d/%b exp=2/2/3/1",
                     pc_sel, reg_addr_sel, reg_data_sel, reg_write_enable);
        end
        drive(enc_r(6'd8), 32'h400, 32'd0);
        vectors++;
        if ({pc_sel, reg_write_enable} !== 3'b11_0) begin
            miscompares++;
            $display("FAIL jr got=%0d/%b exp=3/0", pc_sel, reg_write_enable);
        end
    endtask

    task automatic test_reset_midrun;
        @(negedge clk);
        drive(enc_r(6'd17), 32'd7, 32'd0);
        @(posedge clk);
        @(negedge clk);
        drive(enc_r(6'd16), 32'd0, 32'd0);
        vectors++;
        if (alu_result !== 32'd7) begin
            miscompares++;
            $display("FAIL mthi got=%h exp=00000007", alu_result);
        end
        reset = 1'b0;
        #1;
        vectors++;
        if (alu_result !== 32'd0) begin
            miscompares++;
            $display("FAIL midreset_hi got=%h exp=00000000", alu_result);
        end
        drive(enc_r(6'd33), 32'd1, 32'd1);
        vectors++;
        if (reg_write_enable !== 1'b0) begin
            miscompares++;
            $display("FAIL midreset_we got=%b exp=0", reg_write_enable);
        end
        drive(enc_i(6'd43, 16'd4), 32'h20, 32'd1);
        vectors++;
        if ({data_write, data_read} !== 2'b00) begin
            miscompares++;
            $display("FAIL midreset_sw got=%b exp=00", {data_write, data_read});
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    function automatic logic [31:0] pick_val();
        logic [31:0] v;
        case ($urandom_range(0, 5))
            0: v = 32'd0;
            1: v = 32'h8000_0000;
            2: v = 32'hFFFF_FFFF;
            3: v = {28'd0, 4'($urandom_range(0, 15))};
            default: v = $urandom;
        endcase
        return v;
    endfunction

    task automatic test_random;
        logic [63:0] hilo, nxt;
        logic [31:0] w, a, b;
        logic on;
        exp_t e, got;
        hilo = 64'd0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            w = $urandom;
            case ($urandom_range(0, 7))
                0: ;
                1, 2, 3: begin w[31:26] = 6'd0; w[5:0] = spec_f[$urandom_range(0, 22)]; end
                4: begin w[31:26] = 6'd1; w[20:16] = ri_rt[$urandom_range(0, 3)]; end
                default: w[31:26] = main_op[$urandom_range(0, 21)];
            endcase
            a = pick_val();
            b = ($urandom_range(0, 3) == 0) ? a : pick_val();
            clk_enable = ($urandom_range(0, 9) != 0);
            active = ($urandom_range(0, 9) != 0);
            drive(w, a, b);
            on = clk_enable & active;
            e = model(w, a, b, hilo[63:32], hilo[31:0], on);
            nxt = hilo_step(w, a, b, hilo, on);
            got = {alu_result, branch_is_true, pc_sel, reg_addr_sel, reg_data_sel,
                   alu_sel, signextend_sel, reg_write_enable, data_write,
                   data_read, byte_enable};
            vectors++;
            if (got !== e) begin
                miscompares++;
                $display("FAIL rand[%0d] ins=%h a=%h b=%h en=%b got=%h exp=%h",
                         i, w, a, b, on, got, e);
            end
            @(posedge clk);
            hilo = nxt;
        end
        clk_enable = 1'b1;
        active = 1'b1;
    endtask

    initial begin
        test_reset;
        test_addu;
        test_branch;
        test_store_byte;
        test_muldiv;
        test_jumps;
        test_reset_midrun;
        test_random;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
